// File: rtl/tbu.sv
// Traceback unit for a 4-state Viterbi decoder: buffers one block of survivor decisions,
// picks the lowest-metric final state, traces back, and streams decoded bits oldest first.
module tbu #(
    parameter int unsigned BLK = 8,
    parameter int unsigned PMW = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           d0,
    input  logic           d1,
    input  logic           d2,
    input  logic           d3,
    input  logic [PMW-1:0] pm0,
    input  logic [PMW-1:0] pm1,
    input  logic [PMW-1:0] pm2,
    input  logic [PMW-1:0] pm3,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           out_bit,
    output logic           out_last,
    output logic [1:0]     best_state
);

    localparam int unsigned PW = (BLK > 1) ? $clog2(BLK) : 1;
    localparam logic [PW-1:0] Last = PW'(BLK - 1);

    typedef enum logic [1:0] {StFill, StSelect, StTrace, StEmit} state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   wptr_q, rptr_q, optr_q;
    logic [1:0]      cur_q, best_q, best_d;
    logic [BLK-1:0]  obuf_q;
    logic [3:0]      mem [BLK];

    logic            fill_wr, last_wr, trace_done, emit_hs, emit_end;
    logic [PMW-1:0]  min01, min23;
    logic [1:0]      idx01, idx23;

    assign fill_wr    = (state_q == StFill) && in_valid;
    assign last_wr    = fill_wr && (wptr_q == Last);
    assign trace_done = (state_q == StTrace) && (rptr_q == '0);
    assign emit_hs    = (state_q == StEmit) && out_ready;
    assign emit_end   = emit_hs && (optr_q == Last);

    // Strict less-than keeps ties on the lower index at both tree levels.
    always_comb begin
        idx01  = (pm1 < pm0) ? 2'd1 : 2'd0;
        min01  = (pm1 < pm0) ? pm1 : pm0;
        idx23  = (pm3 < pm2) ? 2'd3 : 2'd2;
        min23  = (pm3 < pm2) ? pm3 : pm2;
        best_d = (min23 < min01) ? idx23 : idx01;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StFill;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFill:   if (last_wr)    state_d = StSelect;
            StSelect:                 state_d = StTrace;
            StTrace:  if (trace_done) state_d = StEmit;
            StEmit:   if (emit_end)   state_d = StFill;
            default:                  state_d = StFill;
        endcase
    end

    always_comb begin
        in_ready   = (state_q == StFill);
        out_valid  = (state_q == StEmit);
        out_bit    = (state_q == StEmit) ? obuf_q[optr_q] : 1'b0;
        out_last   = (state_q == StEmit) && (optr_q == Last);
        best_state = best_q;
    end

    // Decision memory needs no reset; contents are always rewritten before use.
    always_ff @(posedge clk) begin
        if (fill_wr) begin
            mem[wptr_q] <= {d3, d2, d1, d0};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            optr_q <= '0;
            cur_q  <= '0;
            best_q <= '0;
            obuf_q <= '0;
        end else begin
            unique case (state_q)
                StFill: begin
                    if (fill_wr) begin
                        wptr_q <= last_wr ? '0 : wptr_q + PW'(1);
                    end
                end
                StSelect: begin
                    best_q <= best_d;
                    cur_q  <= best_d;
                    rptr_q <= Last;
                end
                StTrace: begin
                    obuf_q[rptr_q] <= cur_q[1];
                    // Step to predecessor {s0, d_s}.
                    cur_q  <= {cur_q[0], mem[rptr_q][cur_q]};
                    rptr_q <= trace_done ? '0 : rptr_q - PW'(1);
                end
                StEmit: begin
                    if (emit_hs) begin
                        optr_q <= emit_end ? '0 : optr_q + PW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/tbu.md
# tbu

Traceback unit of the 4-state Viterbi decoder, directly downstream of the ACS stage and the path metric state memory. Stores one block of per-state survivor decision bits, picks the final state with the lowest registered path metric, traces back through the stored decisions, and streams the decoded bits out in time order with a valid/ready handshake. Holds off upstream with `in_ready` while tracing and emitting.

## Interface
- `BLK`, 8: decision vectors per block (2..64); sets traceback length and output burst length
- `PMW`, 4: path metric width, matching the path metric state memory
- `clk` input 1: clock; all state updates on rising edge
- `reset` input 1: asynchronous, active-low reset
- `in_valid` input 1: decision vector `d0..d3` valid this cycle
- `in_ready` output 1: unit accepts a decision vector; high only in FILL
- `d0`,`d1`,`d2`,`d3` input 1 each: ACS decision for state 0..3; selects the predecessor's low bit
- `pm0`,`pm1`,`pm2`,`pm3` input PMW each: registered normalised path metrics
- `out_valid` output 1: `out_bit` valid
- `out_ready` input 1: downstream accepts `out_bit`
- `out_bit` output 1: decoded bit, oldest first
- `out_last` output 1: qualifies the final bit of a block
- `best_state` output 2: final state chosen for the current block

## Operation
- Trellis: state s = {s1,s0}. Bit decoded at s is s1. Predecessor of s is {s0, d_s}.
- Storage: BLK x 4-bit decision memory indexed by `wptr`/`rptr`; BLK-bit output register `obuf`.
- FSM states:
  - FILL: `in_ready`=1. Each `in_valid` cycle writes {d3,d2,d1,d0} to mem[wptr] and increments `wptr`. Accepting the write at `wptr`=BLK-1 goes to SELECT and resets `wptr` to 0.
  - SELECT: one cycle. Registers `best_state` = argmin(pm0..pm3), unsigned compare, ties to the lowest index. The full PMW value 15 counts as a normal value. Sets `rptr`=BLK-1. Goes to TRACE.
  - TRACE: BLK cycles. Each cycle: `obuf[rptr]` = cur[1]; cur <= {cur[0], mem[rptr][cur]}; `rptr` decrements. `cur` is loaded from `best_state` on entry. Goes to EMIT after `rptr`=0.
  - EMIT: `out_valid`=1 and `out_bit`=`obuf[optr]`, with `optr` starting at 0. `optr` advances on `out_valid && out_ready`. `out_last`=1 when `optr`=BLK-1. Handshake on the last bit goes to FILL.
- `in_valid` outside FILL is ignored; no write and no pointer change.
- Upstream holds `pm0..pm3` at the metrics for the final accepted vector during the SELECT cycle.
- Stalls: while `out_ready`=0, `out_bit`, `out_last` and `optr` hold. `out_valid` never drops before the handshake.

## Timing
- Reset (asynchronous, `reset`=0) gives:
  - state FILL, `in_ready`=1
  - `out_valid`=0, `out_bit`=0, `out_last`=0, `best_state`=0
  - all pointers 0
- Memory contents are don't-care after reset.
- Reset asserted mid-operation aborts the block and discards partial data. FILL resumes on the first edge after release.
- Latency: last vector accepted at edge E. SELECT occupies E..E+1. TRACE occupies E+1..E+BLK+1. `out_valid` rises after edge E+BLK+1.
- Minimum block period: BLK (FILL) + 1 + BLK + BLK cycles (EMIT with `out_ready` held high).
- `in_ready` falls after edge E and rises after the edge of the last output handshake.

## Test plan
- All-zero block, BLK=8: d all 0, pm={0,15,15,15} -> `best_state`=0, eight `out_bit`=0, `out_last` on the eighth.
- All-ones block: d all 1, pm={9,9,9,2} -> `best_state`=3, eight 1s.
- Mixed path, BLK=4:
  - stimulus: pm={7,3,0,3}, d2[3]=1, d1[2]=0, d2[1]=0, all other decisions 0
  - required: `best_state`=2, outputs 0,1,0,1 in order
- Tie-break: pm={5,5,5,5} -> `best_state`=0. Then pm={6,4,4,6} -> `best_state`=1.
- Backpressure:
  - `out_ready` low for 3 cycles at `optr`=2 -> `out_bit` is stable, no bit lost or duplicated
  - `in_valid`=1 throughout TRACE/EMIT -> nothing written, `in_ready`=0
- Reset mid-TRACE -> `out_valid`=0 and `in_ready`=1 immediately. A following full block decodes correctly.
